// File: rtl/zion_rvi_bits_op_arbiter.sv
// Round-robin arbiter sharing one AND/OR/XOR logic unit among NUM_REQ issue slots.
// Latency: one cycle from accepted request to registered, ID-tagged response.
// Backpressure: requests are accepted only while the single response register is empty or draining.

// Shared bitwise-logic execution unit, purely combinational.
// Exactly one enable (or none) is expected; no enable yields an all-zero result.
// No flow control of its own; the arbiter owns handshaking.
module zion_rvi_bits_op_exec #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 and_en_i,
    input  logic                 or_en_i,
    input  logic                 xor_en_i,
    input  logic [CPU_WIDTH-1:0] s1_i,
    input  logic [CPU_WIDTH-1:0] s2_i,
    output logic [CPU_WIDTH-1:0] rslt_o
);

    logic [CPU_WIDTH-1:0] and_rslt;
    logic [CPU_WIDTH-1:0] or_rslt;
    logic [CPU_WIDTH-1:0] xor_rslt;

    assign and_rslt = s1_i & s2_i;
    assign or_rslt  = s1_i | s2_i;
    assign xor_rslt = s1_i ^ s2_i;

    // AND-OR mux of the three results keyed by the one-hot enables.
    assign rslt_o = ({CPU_WIDTH{and_en_i}} & and_rslt)
                  | ({CPU_WIDTH{or_en_i}}  & or_rslt)
                  | ({CPU_WIDTH{xor_en_i}} & xor_rslt);

endmodule

// Round-robin arbiter sharing one AND/OR/XOR logic unit among NUM_REQ issue slots.
// Latency: one cycle from accepted request to registered, ID-tagged response.
// Backpressure: requests are accepted only while the single response register is empty or draining.
module zion_rvi_bits_op_arbiter #(
    parameter  int RV64      = 0,
    parameter  int NUM_REQ   = 4,
    localparam int CPU_WIDTH = 32 * (RV64 + 1),
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             iReqVld,
    output logic [NUM_REQ-1:0]             oReqRdy,
    input  logic [2*NUM_REQ-1:0]           iReqOp,
    input  logic [CPU_WIDTH*NUM_REQ-1:0]   iReqS1,
    input  logic [CPU_WIDTH*NUM_REQ-1:0]   iReqS2,
    output logic                           oRspVld,
    input  logic                           iRspRdy,
    output logic [CPU_WIDTH-1:0]           oRspRslt,
    output logic [ID_W-1:0]                oRspId,
    output logic                           oRspErr,
    output logic [31:0]                    oIssueCnt
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    // Architectural state.
    logic [ID_W-1:0]      ptr_q,       ptr_d;
    logic                 rsp_vld_q,   rsp_vld_d;
    logic [CPU_WIDTH-1:0] rsp_rslt_q,  rsp_rslt_d;
    logic [ID_W-1:0]      rsp_id_q,    rsp_id_d;
    logic                 rsp_err_q,   rsp_err_d;
    logic [31:0]          issue_cnt_q, issue_cnt_d;

    // Arbitration and datapath wires.
    logic                 can_accept;
    logic [ID_W-1:0]      scan_idx [NUM_REQ];
    logic                 win_vld;
    logic [ID_W-1:0]      win_idx;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 xfer;
    logic [ID_W-1:0]      ptr_inc;
    logic [1:0]           sel_op;
    logic [CPU_WIDTH-1:0] sel_s1;
    logic [CPU_WIDTH-1:0] sel_s2;
    logic                 and_en;
    logic                 or_en;
    logic                 xor_en;
    logic                 op_illegal;
    logic [CPU_WIDTH-1:0] exec_rslt;

    // The output register can take a new result if it is empty or being drained this cycle.
    assign can_accept = !rsp_vld_q || iRspRdy;

    // Scan order starts at the RR pointer and wraps modulo NUM_REQ.
    // The sum never reaches 2*NUM_REQ, so one conditional subtract is enough.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_scan
        logic [ID_W:0] sum;
        assign sum         = {1'b0, ptr_q} + (ID_W + 1)'(g);
        assign scan_idx[g] = (sum >= NUM_REQ_W) ? ID_W'(sum - NUM_REQ_W) : sum[ID_W-1:0];
    end

    // First valid requester in scan order wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && iReqVld[scan_idx[i]]) begin
                win_vld = 1'b1;
                win_idx = scan_idx[i];
            end
        end
    end

    // One-hot form of the winner, used to drive the per-port ready.
    always_comb begin
        win_onehot = '0;
        if (win_vld) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

    // Ready is held low during reset so nothing is handshaken into a state about to be cleared.
    assign xfer    = win_vld && can_accept && !rst;
    assign oReqRdy = xfer ? win_onehot : '0;

    // Pointer advances to the slot just after the winner.
    assign ptr_inc = (win_idx == LAST_IDX) ? '0 : win_idx + ID_W'(1);

    // Route the winner's opcode and operands to the shared unit.
    always_comb begin
        sel_op = '0;
        sel_s1 = '0;
        sel_s2 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == ID_W'(k)) begin
                sel_op = iReqOp[2*k +: 2];
                sel_s1 = iReqS1[CPU_WIDTH*k +: CPU_WIDTH];
                sel_s2 = iReqS2[CPU_WIDTH*k +: CPU_WIDTH];
            end
        end
    end

    // Opcode to one-hot enables; the illegal code enables nothing, giving a zero result.
    always_comb begin
        and_en = 1'b0;
        or_en  = 1'b0;
        xor_en = 1'b0;
        case (sel_op)
            2'd0:    and_en = 1'b1;
            2'd1:    or_en  = 1'b1;
            2'd2:    xor_en = 1'b1;
            default: ;
        endcase
    end

    assign op_illegal = (sel_op == 2'd3);

    zion_rvi_bits_op_exec #(
        .CPU_WIDTH (CPU_WIDTH)
    ) u_exec (
        .and_en_i (and_en),
        .or_en_i  (or_en),
        .xor_en_i (xor_en),
        .s1_i     (sel_s1),
        .s2_i     (sel_s2),
        .rslt_o   (exec_rslt)
    );

    // Next state: load on transfer, otherwise clear valid once the consumer takes the response.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_vld_d   = rsp_vld_q;
        rsp_rslt_d  = rsp_rslt_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        issue_cnt_d = issue_cnt_q;
        if (xfer) begin
            rsp_vld_d   = 1'b1;
            rsp_rslt_d  = exec_rslt;
            rsp_id_d    = win_idx;
            rsp_err_d   = op_illegal;
            ptr_d       = ptr_inc;
            issue_cnt_d = issue_cnt_q + 32'd1;
        end else if (iRspRdy) begin
            rsp_vld_d   = 1'b0;
        end
    end

    // State registers with synchronous reset; a pending response is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rslt_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rslt_q  <= rsp_rslt_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign oRspVld   = rsp_vld_q;
    assign oRspRslt  = rsp_rslt_q;
    assign oRspId    = rsp_id_q;
    assign oRspErr   = rsp_err_q;
    assign oIssueCnt = issue_cnt_q;

endmodule

// File: tb/tb_zion_rvi_bits_op_arbiter.sv
// Bench for the shared bitwise-op arbiter, RV64 build with four requesters.
// Directed vector table followed by randomized traffic against a reference model.
// Inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
module tb_zion_rvi_bits_op_arbiter;

    localparam int W = 64;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_rdy;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_s1;
    logic [W*N-1:0] req_s2;
    logic           rsp_vld;
    logic           rsp_rdy;
    logic [W-1:0]   rsp_rslt;
    logic [1:0]     rsp_id;
    logic           rsp_err;
    logic [31:0]    issue_cnt;

    int checks   = 0;
    int failures = 0;

    zion_rvi_bits_op_arbiter #(
        .RV64    (1),
        .NUM_REQ (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iReqVld   (req_vld),
        .oReqRdy   (req_rdy),
        .iReqOp    (req_op),
        .iReqS1    (req_s1),
        .iReqS2    (req_s2),
        .oRspVld   (rsp_vld),
        .iRspRdy   (rsp_rdy),
        .oRspRslt  (rsp_rslt),
        .oRspId    (rsp_id),
        .oRspErr   (rsp_err),
        .oIssueCnt (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [7:0]  op;
        logic [63:0] s1;
        logic [63:0] s2;
        logic        rdy;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic        chk_dat;
        logic [63:0] e_rslt;
        logic [1:0]  e_id;
        logic        e_err;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [7:0] op,
                                input logic [63:0] a, input logic [63:0] b, input logic rr,
                                input logic [3:0] er, input logic ev, input logic cd,
                                input logic [63:0] ers, input logic [1:0] eid, input logic ee,
                                input logic [31:0] ec);
        vec_t t;
        t.rst = r; t.vld = v; t.op = op; t.s1 = a; t.s2 = b; t.rdy = rr;
        t.e_rdy = er; t.e_vld = ev; t.chk_dat = cd; t.e_rslt = ers;
        t.e_id = eid; t.e_err = ee; t.e_cnt = ec;
        return t;
    endfunction

    // Reference model state: what the response port and pointer should hold.
    int          m_ptr;
    logic        m_vld;
    logic [63:0] m_rslt;
    logic [1:0]  m_id;
    logic        m_err;
    logic [31:0] m_cnt;

    initial begin
        rst = 1'b1; req_vld = '0; req_op = '0; req_s1 = '0; req_s2 = '0; rsp_rdy = 1'b0;

        // Reset state, and ready held low while reset is asserted.
        repeat (3) @(posedge clk);
        #1;
        req_vld = 4'hF;
        #1;
        chk("reset_rdy", 64'(req_rdy), 64'h0);
        chk("reset_vld", 64'(rsp_vld), 64'h0);
        chk("reset_rslt", rsp_rslt, 64'h0);
        chk("reset_id", 64'(rsp_id), 64'h0);
        chk("reset_err", 64'(rsp_err), 64'h0);
        chk("reset_cnt", 64'(issue_cnt), 64'h0);
        @(posedge clk);
        #1;

        // Directed table: each row is one cycle; e_rdy is checked in-cycle, the rest after the edge.
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(0, 4'hF, 8'h55, 64'h1, 64'h2, 1, 4'(1 << (i % 4)), 1, 1, 64'h3, 2'(i % 4), 0, 32'(i + 1));
        tbl[8]  = mk(0, 4'h4, 8'h00, 64'hF0F0_00FF, 64'h0FF0_0F0F, 1, 4'h4, 1, 1, 64'h00F0_000F, 2, 0, 9);
        tbl[9]  = mk(0, 4'h2, 8'h04, 64'h1234_0000, 64'h0000_5678, 1, 4'h2, 1, 1, 64'h1234_5678, 1, 0, 10);
        for (int i = 10; i < 13; i++)
            tbl[i] = mk(0, 4'hF, 8'h55, 64'h1, 64'h2, 0, 4'h0, 1, 1, 64'h1234_5678, 1, 0, 10);
        tbl[13] = mk(0, 4'hF, 8'h55, 64'h1, 64'h2, 1, 4'h4, 1, 1, 64'h3, 2, 0, 11);
        tbl[14] = mk(0, 4'h8, 8'hC0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 4'h8, 1, 1, 64'h0, 3, 1, 12);
        tbl[15] = mk(0, 4'h1, 8'h02, 64'hAAAA_AAAA_5555_5555, 64'hFFFF_FFFF_0000_0000, 1, 4'h1,
                     1, 1, 64'h5555_5555_5555_5555, 0, 0, 13);
        tbl[16] = mk(0, 4'h0, 8'h00, 64'h0, 64'h0, 1, 4'h0, 0, 0, 64'h0, 0, 0, 13);
        tbl[17] = mk(0, 4'h1, 8'h00, 64'hFF, 64'hFF, 0, 4'h1, 1, 1, 64'hFF, 0, 0, 14);
        tbl[18] = mk(1, 4'hF, 8'h55, 64'h1, 64'h2, 0, 4'h0, 0, 1, 64'h0, 0, 0, 0);
        tbl[19] = mk(0, 4'hF, 8'h55, 64'h1, 64'h2, 1, 4'h1, 1, 1, 64'h3, 0, 0, 1);
        tbl[20] = mk(0, 4'h0, 8'h55, 64'h1, 64'h2, 0, 4'h0, 1, 1, 64'h3, 0, 0, 1);
        tbl[21] = mk(0, 4'hA, 8'h55, 64'h1, 64'h2, 1, 4'h2, 1, 1, 64'h3, 1, 0, 2);
        tbl[22] = mk(0, 4'h1, 8'h55, 64'h1, 64'h2, 1, 4'h1, 1, 1, 64'h3, 0, 0, 3);

        for (int i = 0; i < 23; i++) begin
            rst     = tbl[i].rst;
            req_vld = tbl[i].vld;
            req_op  = tbl[i].op;
            req_s1  = {N{tbl[i].s1}};
            req_s2  = {N{tbl[i].s2}};
            rsp_rdy = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d_req_rdy", i), 64'(req_rdy), 64'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_rsp_vld", i), 64'(rsp_vld), 64'(tbl[i].e_vld));
            chk($sformatf("row%0d_issue_cnt", i), 64'(issue_cnt), 64'(tbl[i].e_cnt));
            if (tbl[i].chk_dat) begin
                chk($sformatf("row%0d_rslt", i), rsp_rslt, tbl[i].e_rslt);
                chk($sformatf("row%0d_id", i), 64'(rsp_id), 64'(tbl[i].e_id));
                chk($sformatf("row%0d_err", i), 64'(rsp_err), 64'(tbl[i].e_err));
            end
        end

        // Randomized traffic: start from a clean reset so model and DUT agree.
        rst = 1'b1; req_vld = '0; rsp_rdy = 1'b0;
        @(posedge clk);
        #1;
        m_ptr = 0; m_vld = 1'b0; m_rslt = '0; m_id = '0; m_err = 1'b0; m_cnt = '0;

        for (int c = 0; c < 3000; c++) begin
            int          win;
            logic        can;
            logic [3:0]  e_rdy;
            logic [1:0]  op;
            logic [63:0] a;
            logic [63:0] b;
            logic [63:0] r;

            rst     = ($urandom_range(0, 199) == 0);
            req_vld = 4'($urandom_range(0, 15)) & ((c % 64 < 32) ? 4'hF : 4'($urandom_range(0, 15)));
            req_op  = 8'($urandom);
            for (int k = 0; k < N; k++) begin
                req_s1[W*k +: W] = {$urandom, $urandom};
                req_s2[W*k +: W] = {$urandom, $urandom};
            end
            rsp_rdy = ($urandom_range(0, 3) != 0);
            #1;

            // Registered outputs reflect the model's current state.
            chk("rand_rsp_vld", 64'(rsp_vld), 64'(m_vld));
            chk("rand_issue_cnt", 64'(issue_cnt), 64'(m_cnt));
            if (m_vld) begin
                chk("rand_rslt", rsp_rslt, m_rslt);
                chk("rand_id", 64'(rsp_id), 64'(m_id));
                chk("rand_err", 64'(rsp_err), 64'(m_err));
            end

            // Winner: first valid requester counting up from the pointer, modulo N.
            win = -1;
            for (int off = 0; off < N; off++) begin
                int k;
                k = (m_ptr + off) % N;
                if (win < 0 && req_vld[k]) win = k;
            end
            can   = !m_vld || rsp_rdy;
            e_rdy = (!rst && can && win >= 0) ? 4'(1 << win) : 4'h0;
            chk("rand_req_rdy", 64'(req_rdy), 64'(e_rdy));

            @(posedge clk);
            #1;
            if (rst) begin
                m_ptr = 0; m_vld = 1'b0; m_rslt = '0; m_id = '0; m_err = 1'b0; m_cnt = '0;
            end else if (e_rdy != 4'h0) begin
                op = req_op[2*win +: 2];
                a  = req_s1[W*win +: W];
                b  = req_s2[W*win +: W];
                case (op)
                    2'd0:    r = a & b;
                    2'd1:    r = a | b;
                    2'd2:    r = a ^ b;
                    default: r = '0;
                endcase
                m_vld  = 1'b1;
                m_rslt = r;
                m_id   = 2'(win);
                m_err  = (op == 2'd3);
                m_ptr  = (win + 1) % N;
                m_cnt  = m_cnt + 32'd1;
            end else if (rsp_rdy) begin
                m_vld = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
